// File: rtl/router_pkg.sv
// Shared router constants: data width, header field positions and packet-count width.
package router_pkg;

  localparam int unsigned ROUTER_DATA_W = 8;

  localparam int unsigned HDR_LEN_MSB  = 7;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_ADDR_LSB = 0;

  localparam int unsigned PKT_CNT_W = 7;

endpackage

// File: rtl/router_fifo_if.sv
// Push/pop handshake bundle between the register stage, one output FIFO and its destination.
// Optional almost_full signal present only when ROUTER_FIFO_ALMOST_FULL_EN is defined.
interface router_fifo_if #(
  parameter int unsigned WIDTH = router_pkg::ROUTER_DATA_W
);

  logic             soft_reset;
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             empty;
  logic             full;
  logic             pkt_active;
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
  logic             almost_full;
`endif

  // Upstream/destination side: drives requests, observes status and read data
  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    input  almost_full,
`endif
    input  data_out, data_valid, empty, full, pkt_active
  );

  // FIFO side
  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    output almost_full,
`endif
    output data_out, data_valid, empty, full, pkt_active
  );

endinterface

// File: rtl/router_fifo_mem.sv
// Storage array for router_fifo: synchronous write port, asynchronous read by index.
module router_fifo_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WORD_W = 9
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WORD_W-1:0]        rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write the accepted word; contents are not reset, pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router. Stores {header marker, byte}, tracks
// remaining payload+parity bytes of the packet being read out, registers popped data.
// Optional feature: ROUTER_FIFO_ALMOST_FULL_EN adds almost_full (occupancy >= DEPTH-1).
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = ROUTER_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  router_fifo_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PTR_W  = AW + 1;
  localparam int unsigned WORD_W = WIDTH + 1;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [WORD_W-1:0]    rd_word;
  logic [WIDTH-1:0]     data_out_q;
  logic                 data_valid_q;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic                 empty_c;
  logic                 full_c;
  logic                 pop_c;
  logic                 push_c;
  logic                 flush_c;

  assign flush_c = !rst || bus.soft_reset;

  // Flags straight from the registered pointers; the MSB is the wrap flag
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
  assign pop_c  = bus.read_enb && !empty_c;
  assign push_c = bus.write_enb && (!full_c || pop_c);

  router_fifo_mem #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_c && !flush_c),
    .wr_idx  (wr_ptr[AW-1:0]),
    .wr_data ({bus.lfd_state, bus.data_in}),
    .rd_idx  (rd_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  // Pointer advance; the wrap flag toggles naturally as the index rolls over
  always_ff @(posedge clk) begin
    if (flush_c) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Registered read data with a one-cycle valid pulse per accepted pop
  always_ff @(posedge clk) begin
    if (flush_c) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= pop_c;
      if (pop_c) data_out_q <= rd_word[WIDTH-1:0];
    end
  end

  // Remaining payload+parity count; a header always reloads it, even mid-packet
  always_ff @(posedge clk) begin
    if (flush_c) begin
      pkt_cnt <= '0;
    end else if (pop_c) begin
      if (rd_word[WORD_W-1]) begin
        pkt_cnt <= PKT_CNT_W'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
      end else if (pkt_cnt != '0) begin
        pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.empty      = empty_c;
  assign bus.full       = full_c;
  assign bus.pkt_active = (pkt_cnt != '0);

`ifdef ROUTER_FIFO_ALMOST_FULL_EN
  logic [PTR_W-1:0] occupancy_c;

  // Pointer difference is the occupancy, wrap flag included
  assign occupancy_c     = wr_ptr - rd_ptr;
  assign bus.almost_full = (occupancy_c >= PTR_W'(DEPTH - 1));
`endif

endmodule
